// File: rtl/control_sequencer_if.sv
// Instruction-memory fetch bus between the control sequencer (master) and
// the instruction memory (slave).
interface control_sequencer_if #(
    parameter int OP_W = 4,
    parameter int PC_W = 8
);
    logic            imem_req;
    logic [PC_W-1:0] imem_addr;
    logic            imem_valid;
    logic [OP_W-1:0] imem_data;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_valid,
        input  imem_data
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_valid,
        output imem_data
    );
endinterface

// File: rtl/control_sequencer.sv
// Fetch/wait/execute sequencer: steps a PC from 0 to pc_limit, fetching one
// opcode per step and emitting a one-hot control strobe for it.
module control_sequencer #(
    parameter int OP_W  = 4,
    parameter int PC_W  = 8,
    parameter int DIV_W = 4
) (
    input  logic                 CLKin,
    input  logic                 RSTn,
    input  logic                 start,
    input  logic                 stop,
    input  logic [PC_W-1:0]      pc_limit,
    input  logic [DIV_W-1:0]     tick_div,
    control_sequencer_if.master  imem,
    output logic [2**OP_W-1:0]   ctrl,
    output logic                 ctrl_valid,
    output logic                 busy,
    output logic                 done
);
    localparam int CTRL_W = 2**OP_W;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT,
        S_EXEC,
        S_DONE
    } state_t;

    state_t             state, state_next;
    logic [PC_W-1:0]    pc, pc_next;
    logic [OP_W-1:0]    opcode, opcode_next;
    logic [DIV_W-1:0]   div_cnt, div_cnt_next;
    logic [DIV_W-1:0]   div_lim, div_lim_next;

    assign imem.imem_addr = pc;

    always_ff @(posedge CLKin or negedge RSTn) begin
        if (!RSTn) begin
            state   <= S_IDLE;
            pc      <= '0;
            opcode  <= '0;
            div_cnt <= '0;
            div_lim <= '0;
        end else begin
            state   <= state_next;
            pc      <= pc_next;
            opcode  <= opcode_next;
            div_cnt <= div_cnt_next;
            div_lim <= div_lim_next;
        end
    end

    // tick_div is captured into div_lim on FETCH exit so later changes only
    // affect the next instruction; stop always takes priority over progress.
    always_comb begin
        state_next    = state;
        pc_next       = pc;
        opcode_next   = opcode;
        div_cnt_next  = div_cnt;
        div_lim_next  = div_lim;
        imem.imem_req = 1'b0;
        ctrl          = '0;
        ctrl_valid    = 1'b0;
        busy          = 1'b1;
        done          = 1'b0;

        case (state)
            S_IDLE: begin
                busy = 1'b0;
                if (start && !stop) begin
                    pc_next    = '0;
                    state_next = S_FETCH;
                end
            end
            S_FETCH: begin
                imem.imem_req = 1'b1;
                if (stop) begin
                    state_next = S_IDLE;
                end else if (imem.imem_valid) begin
                    opcode_next = imem.imem_data;
                    if (tick_div != '0) begin
                        div_cnt_next = '0;
                        div_lim_next = tick_div;
                        state_next   = S_WAIT;
                    end else begin
                        state_next = S_EXEC;
                    end
                end
            end
            S_WAIT: begin
                div_cnt_next = div_cnt + DIV_W'(1);
                if (stop) begin
                    state_next = S_IDLE;
                end else if (div_cnt == div_lim - DIV_W'(1)) begin
                    state_next = S_EXEC;
                end
            end
            S_EXEC: begin
                ctrl       = CTRL_W'(1) << opcode;
                ctrl_valid = 1'b1;
                if (stop) begin
                    state_next = S_IDLE;
                end else if (pc == pc_limit) begin
                    state_next = S_DONE;
                end else begin
                    pc_next    = pc + PC_W'(1);
                    state_next = S_FETCH;
                end
            end
            S_DONE: begin
                done       = 1'b1;
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end
endmodule

// File: tb/tb_control_sequencer.sv
// Randomized scoreboard bench for control_sequencer: an instruction memory
// model with configurable fetch latency and a per-instruction expectation queue.
module tb_control_sequencer;
    localparam int OP_W   = 4;
    localparam int PC_W   = 8;
    localparam int DIV_W  = 4;
    localparam int CTRL_W = 16;

    logic              CLKin    = 1'b0;
    logic              RSTn     = 1'b0;
    logic              start    = 1'b0;
    logic              stop     = 1'b0;
    logic [PC_W-1:0]   pc_limit = '0;
    logic [DIV_W-1:0]  tick_div = '0;
    logic [CTRL_W-1:0] ctrl;
    logic              ctrl_valid;
    logic              busy;
    logic              done;

    control_sequencer_if #(.OP_W(OP_W), .PC_W(PC_W)) mem_bus ();

    control_sequencer #(.OP_W(OP_W), .PC_W(PC_W), .DIV_W(DIV_W)) dut (
        .CLKin      (CLKin),
        .RSTn       (RSTn),
        .start      (start),
        .stop       (stop),
        .pc_limit   (pc_limit),
        .tick_div   (tick_div),
        .imem       (mem_bus),
        .ctrl       (ctrl),
        .ctrl_valid (ctrl_valid),
        .busy       (busy),
        .done       (done)
    );

    always #5 CLKin = ~CLKin;

    typedef struct {
        logic [CTRL_W-1:0] ctrl;
        logic [PC_W-1:0]   addr;
        int                rel;
    } exp_t;

    exp_t      exp_q[$];
    logic [OP_W-1:0] mem [256];
    int        valid_delay  = 0;
    int        req_cycles   = 0;
    int        cycle_cnt    = 0;
    int        start_cycle  = 0;
    int        done_seen    = 0;
    int        done_rel     = 0;
    int        exp_done_rel = 0;
    int        pass_cnt     = 0;
    int        check_cnt    = 0;

    // Memory answers a request after valid_delay waiting cycles.
    assign mem_bus.imem_valid = mem_bus.imem_req && (req_cycles >= valid_delay);
    assign mem_bus.imem_data  = mem[mem_bus.imem_addr];

    always @(posedge CLKin) begin
        cycle_cnt <= cycle_cnt + 1;
        if (!mem_bus.imem_req || mem_bus.imem_valid)
            req_cycles <= 0;
        else
            req_cycles <= req_cycles + 1;
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
        check_cnt++;
        if (act === req)
            pass_cnt++;
        else
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, req);
    endtask

    // Monitor: every EXEC pops one expectation; outside EXEC ctrl must be
    // zero; a pending fetch must hold its address.
    initial begin
        logic            hold_req;
        logic [PC_W-1:0] hold_addr;
        exp_t            e;
        hold_req  = 1'b0;
        hold_addr = '0;
        forever begin
            @(negedge CLKin);
            if (ctrl_valid) begin
                if (exp_q.size() == 0) begin
                    checkOutput("unexpected_ctrl", 64'(ctrl_valid), 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    checkOutput("ctrl", 64'(ctrl), 64'(e.ctrl));
                    checkOutput("exec_addr", 64'(mem_bus.imem_addr), 64'(e.addr));
                    checkOutput("exec_cycle", 64'(cycle_cnt - start_cycle), 64'(e.rel));
                end
            end else begin
                checkOutput("ctrl_idle", 64'(ctrl), 64'd0);
            end
            if (done) begin
                done_seen++;
                done_rel = cycle_cnt - start_cycle;
            end
            if (mem_bus.imem_req && hold_req)
                checkOutput("addr_stable", 64'(mem_bus.imem_addr), 64'(hold_addr));
            hold_req  = mem_bus.imem_req && !mem_bus.imem_valid;
            hold_addr = mem_bus.imem_addr;
        end
    end

    // Reference model: walk the PC from 0 until it equals the limit in force
    // (late_limit from instruction switch_k on), modulo 256; each step costs
    // delay+1 fetch cycles, td wait cycles and one execute cycle.
    task automatic buildProgram(input int limit, input int late_limit, input int switch_k,
                                input int td, input int delay);
        exp_t e;
        int   pc;
        int   lim;
        int   n;
        pc = 0;
        n  = 0;
        for (int k = 0; k < 1000; k++) begin
            e.ctrl = CTRL_W'(1) << mem[pc];
            e.addr = PC_W'(pc);
            e.rel  = delay + 1 + td + k * (delay + td + 2);
            exp_q.push_back(e);
            n++;
            lim = (k >= switch_k) ? late_limit : limit;
            if (pc == lim) break;
            pc = (pc + 1) % 256;
        end
        exp_done_rel = n * (delay + td + 2);
    endtask

    task automatic pulseStart();
        @(posedge CLKin);
        #1 start = 1'b1;
        @(posedge CLKin);
        #1;
        start       = 1'b0;
        start_cycle = cycle_cnt;
    endtask

    // mode 1: stray start mid-run; mode 2: pc_limit lowered to 3 while PC=5;
    // mode 3: tick_div changed during WAIT.
    task automatic applyStimulus(input int limit, input int td, input int delay, input int mode);
        pc_limit    = PC_W'(limit);
        tick_div    = DIV_W'(td);
        valid_delay = delay;
        done_seen   = 0;
        exp_q.delete();
        buildProgram(limit, 3, (mode == 2) ? 5 : 100000, td, delay);
        pulseStart();
        for (int c = 0; c < 4000 && done_seen == 0; c++) begin
            @(posedge CLKin);
            #1;
            start = (mode == 1 && c == 1);
            if (mode == 2 && c == 9) pc_limit = PC_W'(3);
            if (mode == 3 && c == 0) tick_div = DIV_W'(9);
        end
        start = 1'b0;
        checkOutput("done_count", 64'(done_seen), 64'd1);
        checkOutput("busy_after_done", 64'(busy), 64'd0);
        checkOutput("done_cycle", 64'(done_rel), 64'(exp_done_rel));
        checkOutput("queue_drained", 64'(exp_q.size()), 64'd0);
        repeat (3) @(posedge CLKin);
        #1 checkOutput("done_once", 64'(done_seen), 64'd1);
        exp_q.delete();
    endtask

    task automatic checkAllLow(input string tag);
        checkOutput({tag, "_req"}, 64'(mem_bus.imem_req), 64'd0);
        checkOutput({tag, "_addr"}, 64'(mem_bus.imem_addr), 64'd0);
        checkOutput({tag, "_ctrl"}, 64'(ctrl), 64'd0);
        checkOutput({tag, "_ctrl_valid"}, 64'(ctrl_valid), 64'd0);
        checkOutput({tag, "_busy"}, 64'(busy), 64'd0);
        checkOutput({tag, "_done"}, 64'(done), 64'd0);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = OP_W'($urandom);

        #12 checkAllLow("reset");
        @(negedge CLKin) RSTn = 1'b1;
        repeat (3) @(posedge CLKin);
        #1 checkOutput("idle_after_reset", 64'(busy), 64'd0);

        // Fixed program {10,11,0}
        mem[0] = 4'd10; mem[1] = 4'd11; mem[2] = 4'd0;
        applyStimulus(2, 0, 0, 0);

        // Single opcode 15 with three wait cycles; tick_div changes in WAIT
        mem[0] = 4'd15;
        applyStimulus(0, 3, 0, 3);

        // Slow memory
        applyStimulus(1, 0, 5, 0);

        // stop and start together in IDLE
        @(posedge CLKin);
        #1 begin start = 1'b1; stop = 1'b1; end
        @(posedge CLKin);
        #1 begin start = 1'b0; stop = 1'b0; end
        checkOutput("stop_start_idle", 64'(busy), 64'd0);
        @(posedge CLKin);
        #1 checkOutput("stop_start_idle2", 64'(busy), 64'd0);

        // stop in WAIT: no strobe, no done
        pc_limit = 8'd3; tick_div = 4'd3; valid_delay = 0; done_seen = 0;
        exp_q.delete();
        pulseStart();
        repeat (2) @(posedge CLKin);
        #1 stop = 1'b1;
        @(posedge CLKin);
        #1 stop = 1'b0;
        checkOutput("stop_wait_busy", 64'(busy), 64'd0);
        repeat (8) @(posedge CLKin);
        #1 checkOutput("stop_wait_done", 64'(done_seen), 64'd0);

        // stop in EXEC: one strobe, no done
        done_seen = 0;
        buildProgram(3, 3, 100000, 3, 0);
        while (exp_q.size() > 1) void'(exp_q.pop_back());
        pulseStart();
        repeat (4) @(posedge CLKin);
        #1 stop = 1'b1;
        @(posedge CLKin);
        #1 stop = 1'b0;
        checkOutput("stop_exec_busy", 64'(busy), 64'd0);
        repeat (8) @(posedge CLKin);
        #1;
        checkOutput("stop_exec_done", 64'(done_seen), 64'd0);
        checkOutput("stop_exec_strobe", 64'(exp_q.size()), 64'd0);
        exp_q.delete();

        // Randomized runs
        for (int r = 0; r < 10; r++) begin
            for (int i = 0; i < 256; i++) mem[i] = OP_W'($urandom);
            applyStimulus($urandom_range(0, 7), $urandom_range(0, 5), $urandom_range(0, 3),
                          $urandom_range(0, 1));
        end

        // Wrap-around: limit lowered below PC mid-run
        applyStimulus(200, 0, 0, 2);

        // Asynchronous reset while fetching address 2
        pc_limit = 8'd5; tick_div = 4'd0; valid_delay = 0; done_seen = 0;
        exp_q.delete();
        buildProgram(5, 5, 100000, 0, 0);
        pulseStart();
        repeat (4) @(posedge CLKin);
        #1;
        checkOutput("pre_reset_addr", 64'(mem_bus.imem_addr), 64'd2);
        checkOutput("pre_reset_req", 64'(mem_bus.imem_req), 64'd1);
        #2 RSTn = 1'b0;
        #1 checkAllLow("async_reset");
        checkOutput("reset_strobes_seen", 64'(exp_q.size()), 64'd4);
        exp_q.delete();
        @(posedge CLKin);
        @(negedge CLKin) RSTn = 1'b1;
        repeat (3) @(posedge CLKin);
        #1;
        checkOutput("idle_after_async_reset", 64'(busy), 64'd0);
        checkOutput("no_done_after_reset", 64'(done_seen), 64'd0);
        applyStimulus(3, 1, 0, 0);

        $display("[TB] %0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end
endmodule
